// File: rtl/piccolo_round_function.sv
// Piccolo round-function stage: two-cycle pipeline computing X1^F(X0)^rk0 and X3^F(X2)^rk1.
// Stage 1 holds S-box+diffusion results; stage 2 applies the final S-box layer and XOR.
module piccolo_round_function (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] A,
  input  logic [31:0] rk,
  input  logic        last_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] Q,
  output logic        last_out
);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'he;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hb;  4'h3: sbox = 4'h2;
      4'h4: sbox = 4'h3;  4'h5: sbox = 4'h8;  4'h6: sbox = 4'h0;  4'h7: sbox = 4'h9;
      4'h8: sbox = 4'h1;  4'h9: sbox = 4'ha;  4'ha: sbox = 4'h7;  4'hb: sbox = 4'hf;
      4'hc: sbox = 4'h6;  4'hd: sbox = 4'hc;  4'he: sbox = 4'h5;  4'hf: sbox = 4'hd;
      default: sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] x);
    sub16 = {sbox(x[15:12]), sbox(x[11:8]), sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  // Multiplication by x and x+1 in GF(2^4) reduced by x^4+x+1.
  function automatic logic [3:0] gf_x2(input logic [3:0] a);
    gf_x2 = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gf_x3(input logic [3:0] a);
    gf_x3 = gf_x2(a) ^ a;
  endfunction

  function automatic logic [15:0] mix(input logic [15:0] x);
    logic [3:0] n0, n1, n2, n3;
    n0 = x[15:12];
    n1 = x[11:8];
    n2 = x[7:4];
    n3 = x[3:0];
    mix = {gf_x2(n0) ^ gf_x3(n1) ^ n2 ^ n3,
           n0 ^ gf_x2(n1) ^ gf_x3(n2) ^ n3,
           n0 ^ n1 ^ gf_x2(n2) ^ gf_x3(n3),
           gf_x3(n0) ^ n1 ^ n2 ^ gf_x2(n3)};
  endfunction

  logic        adv1_s, adv2_s;
  logic        v1_q, v1_d, v2_q, v2_d;
  logic [15:0] x0_q, x0_d, x2_q, x2_d, x1k_q, x1k_d, x3k_q, x3k_d;
  logic [15:0] m0_q, m0_d, m2_q, m2_d;
  logic        last1_q, last1_d, last2_q, last2_d;
  logic [63:0] q_q, q_d;

  // Handshake advance terms and next-state for both pipeline stages.
  always_comb begin
    adv2_s  = ~v2_q | out_ready;
    adv1_s  = ~v1_q | adv2_s;
    v1_d    = v1_q;
    x0_d    = x0_q;
    x2_d    = x2_q;
    x1k_d   = x1k_q;
    x3k_d   = x3k_q;
    m0_d    = m0_q;
    m2_d    = m2_q;
    last1_d = last1_q;
    v2_d    = v2_q;
    q_d     = q_q;
    last2_d = last2_q;
    if (adv1_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        x0_d    = A[63:48];
        x2_d    = A[31:16];
        x1k_d   = A[47:32] ^ rk[31:16];
        x3k_d   = A[15:0] ^ rk[15:0];
        m0_d    = mix(sub16(A[63:48]));
        m2_d    = mix(sub16(A[31:16]));
        last1_d = last_in;
      end else begin
        last1_d = last1_q;
      end
    end else begin
      v1_d = v1_q;
    end
    if (adv2_s) begin
      v2_d    = v1_q;
      q_d     = {x0_q, x1k_q ^ sub16(m0_q), x2_q, x3k_q ^ sub16(m2_q)};
      last2_d = last1_q;
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline registers; reset discards any beat in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      x0_q    <= 16'h0000;
      x2_q    <= 16'h0000;
      x1k_q   <= 16'h0000;
      x3k_q   <= 16'h0000;
      m0_q    <= 16'h0000;
      m2_q    <= 16'h0000;
      last1_q <= 1'b0;
      v2_q    <= 1'b0;
      q_q     <= 64'h0;
      last2_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      x0_q    <= x0_d;
      x2_q    <= x2_d;
      x1k_q   <= x1k_d;
      x3k_q   <= x3k_d;
      m0_q    <= m0_d;
      m2_q    <= m2_d;
      last1_q <= last1_d;
      v2_q    <= v2_d;
      q_q     <= q_d;
      last2_q <= last2_d;
    end
  end

  assign in_ready  = adv1_s;
  assign out_valid = v2_q;
  assign Q         = q_q;
  assign last_out  = last2_q;

endmodule

// File: tb/tb_piccolo_round_function.sv
// Scoreboard bench for piccolo_round_function: driver pushes expected beats, monitor pops and compares.
module tb_piccolo_round_function;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] A = 64'h0;
  logic [31:0] rk = 32'h0;
  logic        last_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] Q;
  logic        last_out;

  piccolo_round_function dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .rk(rk), .last_in(last_in), .out_valid(out_valid),
    .out_ready(out_ready), .Q(Q), .last_out(last_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic        last;
    int          cyc;
    logic        exact;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [63:0] SBOX_TAB = 64'hE4B238091A7F6C5D;
  localparam int MAT [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};

  function automatic int gf_mul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 4; i++) if ((b >> i) & 1) p ^= a << i;
    for (int i = 6; i >= 4; i--) if ((p >> i) & 1) p ^= 'h13 << (i - 4);
    return p;
  endfunction

  function automatic int sb(input int x);
    logic [63:0] t = SBOX_TAB;
    return int'(t[63 - 4 * x -: 4]);
  endfunction

  function automatic logic [15:0] model_f(input logic [15:0] x);
    int s[4];
    int y[4];
    logic [15:0] r;
    for (int i = 0; i < 4; i++) s[i] = sb(int'(x[15 - 4 * i -: 4]));
    for (int i = 0; i < 4; i++) begin
      y[i] = 0;
      for (int j = 0; j < 4; j++) y[i] ^= gf_mul(MAT[i][j], s[j]);
    end
    for (int i = 0; i < 4; i++) r[15 - 4 * i -: 4] = 4'(sb(y[i]));
    return r;
  endfunction

  function automatic logic [63:0] model_round(input logic [63:0] a, input logic [31:0] k);
    return {a[63:48], a[47:32] ^ model_f(a[63:48]) ^ k[31:16],
            a[31:16], a[15:0] ^ model_f(a[31:16]) ^ k[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; records an expected beat when the handshake fires.
  task automatic drive(input logic iv, input logic [63:0] a, input logic [31:0] k,
                       input logic l, input logic ordy, input logic ex,
                       input logic [63:0] qexp, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    A         = a;
    rk        = k;
    last_in   = l;
    out_ready = ordy;
    #1;
    acc = iv && in_ready && !reset;
    if (acc) begin
      e.q = qexp; e.last = l; e.cyc = cyc; e.exact = ex;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, 64'h0, 32'h0, 1'b0, ordy, 1'b0, 64'h0, acc);
  endtask

  // Monitor: compares each delivered beat and checks hold-stability under backpressure.
  initial begin : monitor
    logic        held_v;
    logic [63:0] held_q;
    logic        held_l;
    exp_t        e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        held_v = 1'b0;
      end else if (out_valid) begin
        if (held_v) begin
          chk("hold_Q", Q, held_q);
          chk("hold_last", 64'(last_out), 64'(held_l));
        end
        if (out_ready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", Q, 64'hx);
          end else begin
            e = exp_q.pop_front();
            chk("Q", Q, e.q);
            chk("last_out", 64'(last_out), 64'(e.last));
            if (e.exact) chk("latency", 64'(cyc - e.cyc), 64'd2);
          end
        end else begin
          held_v = 1'b1;
          held_q = Q;
          held_l = last_out;
        end
      end else if (held_v) begin
        chk("valid_dropped", 64'(out_valid), 64'd1);
        held_v = 1'b0;
      end
    end
  end

  initial begin : driver
    logic        acc;
    logic [63:0] a;
    logic [31:0] k;
    int          n_acc;
    int          wait_cnt;

    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_Q", Q, 64'h0);
    chk("reset_last_out", 64'(last_out), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    drive(1'b1, 64'h0, 32'h0, 1'b0, 1'b1, 1'b1, 64'h0000_5555_0000_5555, acc);
    drive(1'b1, 64'h0001_0000_0000_0000, 32'h0, 1'b0, 1'b1, 1'b1, 64'h0001_332a_0000_5555, acc);
    drive(1'b1, 64'h0, 32'hffff_0000, 1'b1, 1'b1, 1'b1, 64'h0000_aaaa_0000_5555, acc);
    idle(3, 1'b1);

    // Back-to-back stream with no stall.
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      k = $urandom;
      drive(1'b1, a, k, 1'(i == 15), 1'b1, 1'b1, model_round(a, k), acc);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    idle(3, 1'b1);

    // Stall an empty pipeline for five cycles with input pending.
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      a = {$urandom, $urandom};
      k = $urandom;
      drive(1'b1, a, k, 1'($urandom_range(0, 1)), 1'b0, 1'b0, model_round(a, k), acc);
      if (acc) n_acc++;
      if (i >= 2) chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    chk("stall_accepts", 64'(n_acc), 64'd2);
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      k = $urandom;
      drive(1'b1, a, k, 1'b0, 1'b1, 1'b0, model_round(a, k), acc);
    end
    idle(3, 1'b1);

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      a = {$urandom, $urandom};
      k = $urandom;
      drive(1'($urandom_range(0, 3) != 0), a, k, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), 1'b0, model_round(a, k), acc);
    end
    idle(4, 1'b1);

    // Fill the pipeline, then reset with both stages valid.
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom};
      k = $urandom;
      drive(1'b1, a, k, 1'b1, 1'b0, 1'b0, model_round(a, k), acc);
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_Q", Q, 64'h0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    a = 64'h0123_4567_89ab_cdef;
    k = 32'h1357_9bdf;
    drive(1'b1, a, k, 1'b1, 1'b1, 1'b1, model_round(a, k), acc);
    chk("postreset_accept", 64'(acc), 64'd1);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      idle(1, 1'b1);
      wait_cnt++;
    end
    idle(2, 1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
